fault_response_checker: RTL and testbench
=========================================

// Module: fault_response_checker
// PURPOSE
//  Sits directly downstream of the fault-injected adder netlist (128-bit sum f plus cOut) in the batched fault campaign.
//  - Golden pass: captures the fault-free response for each stimulus vector.
//  - Each later fault pass: compares every response against the golden value for the same vector index.
//  - Emits one detection record per fault ID on a valid/ready stream and keeps campaign counters.
//  Replaces text-log diffing of per-vector output dumps with an in-simulation, synthesizable checker.
// PARAMETERS
//  DATA_W   129  response width, {cOut, f[127:0]}
//  NVEC     3    stimulus vectors per pass; legal range 1..MAXVEC
//  MAXVEC   16   golden store depth; sets VIDX_W = $clog2(MAXVEC)
//  FID_W    16   fault ID width
//  CNT_W    16   width of the campaign counters; counters saturate
// PORTS
//  clk           in   1       single clock, rising edge
//  rst_n         in   1       asynchronous active-low reset
//  pass_start    in   1       1-cycle pulse: a pass begins
//  pass_golden   in   1       sampled with pass_start: 1 = golden pass, 0 = fault pass
//  pass_fid      in   FID_W   fault ID, sampled with pass_start
//  resp_valid    in   1       response word valid
//  resp_ready    out  1       checker can accept a response
//  resp_data     in   DATA_W  DUT response for the current vector
//  rec_valid     out  1       detection record valid
//  rec_ready     in   1       record consumer ready
//  rec_fid       out  FID_W   fault ID of the record
//  rec_detected  out  1       at least one vector mismatched
//  rec_first     out  VIDX_W  index of the first mismatching vector; 0 if none
//  rec_mcount    out  VIDX_W+1  number of mismatching vectors
//  golden_ok     out  1       golden store holds a complete pass
//  proto_err     out  1       sticky protocol-error flag
//  n_faults      out  CNT_W   fault records emitted
//  n_detected    out  CNT_W   emitted records with rec_detected = 1
// BEHAVIOUR
//  Reset: every output is 0. FSM goes to IDLE; vidx = 0. Golden RAM contents are don't-care; golden_ok = 0.
//  FSM states and transitions:
//   - IDLE: pass_start & pass_golden -> GOLD. pass_start & !pass_golden & golden_ok -> CHECK.
//     pass_start & !pass_golden & !golden_ok -> stay IDLE and set proto_err.
//   - GOLD: each accepted word writes golden[vidx]. After word NVEC-1: golden_ok = 1, go to IDLE.
//   - CHECK: each accepted word is compared with golden[vidx] over the full DATA_W bits.
//     On a mismatch: mcount++; first = vidx if this is the first mismatch; det = 1.
//     After word NVEC-1 go to EMIT.
//   - EMIT: rec_valid = 1, with fields held stable until rec_valid & rec_ready. On that handshake go to IDLE.
//  Response handshake:
//   - resp_ready = 1 in GOLD and CHECK, 0 in IDLE and EMIT.
//   - A word transfers on resp_valid & resp_ready. vidx increments per transfer and clears at pass start.
//   - A resp_valid seen in IDLE is ignored and sets proto_err. In EMIT the word is back-pressured, not an error.
//  Latency: rec_valid rises the cycle after the last CHECK word transfers. A GOLD->IDLE pass emits no record.
//  Counters: on the record handshake, n_faults++ and n_detected += rec_detected. Both saturate at 2^CNT_W-1.
//  Simultaneous events:
//   - pass_start in GOLD or CHECK: abort the pass, set proto_err, restart per the sampled pass_golden.
//     An aborted GOLD pass also clears golden_ok. An aborted CHECK pass emits no record and is not counted.
//   - pass_start in EMIT: ignored and sets proto_err. The record remains pending.
//   - pass_start and the last resp transfer in the same cycle: pass_start wins; the word is dropped.
//  A new golden pass overwrites the store; golden_ok = 0 until it completes.
//  proto_err clears only on reset.
//  Async reset mid-pass or mid-EMIT: the pending record is discarded and the counters clear.
// TESTING
//  T1 golden then clean fault:
//   - Golden vectors {0,0x0..0}, {0,0x0..0}, {0,0x0..0}.
//   - Fault pass fid=5 with identical words -> record fid=5, det=0, first=0, mcount=0; n_faults=1, n_detected=0.
//  T2 single mismatch:
//   - Fault pass fid=7 with word1 bit f[0] flipped.
//   - Response -> det=1, first=1, mcount=1; n_detected=1.
//  T3 cOut-only mismatch:
//   - Golden word0 = {1,0x0}; fault word0 = {0,0x0}; all other words match.
//   - Response -> det=1, first=0, mcount=1.
//  T4 back-pressure:
//   - Hold rec_ready=0 for 10 cycles after rec_valid.
//   - Response -> fields stable, resp_ready=0 throughout; pass_start in that window -> proto_err=1, record kept.
//  T5 abort:
//   - pass_start (fid=9) after 2 words of fid=8.
//   - Response -> no record for fid 8, proto_err=1; fid 9 completes normally.
//  T6 no golden / saturation:
//   - Fault pass_start right after reset -> proto_err=1, FSM stays in IDLE.
//   - With CNT_W=2, run 5 detected faults -> n_faults = n_detected = 3.

Source files
------------

// File: rtl/fault_response_checker.sv
// fault_response_checker
// Captures the golden (fault-free) response of an adder netlist over NVEC
// stimulus vectors, then compares each later fault pass against it and emits
// one detection record per fault ID on a valid/ready stream. Campaign
// counters of emitted and detected faults saturate at their maximum value.
module fault_response_checker #(
  parameter int DATA_W = 129,
  parameter int NVEC   = 3,
  parameter int MAXVEC = 16,
  parameter int FID_W  = 16,
  parameter int CNT_W  = 16,
  localparam int VIDX_W = $clog2(MAXVEC)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pass_start,
  input  logic              pass_golden,
  input  logic [FID_W-1:0]  pass_fid,
  input  logic              resp_valid,
  output logic              resp_ready,
  input  logic [DATA_W-1:0] resp_data,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic [FID_W-1:0]  rec_fid,
  output logic              rec_detected,
  output logic [VIDX_W-1:0] rec_first,
  output logic [VIDX_W:0]   rec_mcount,
  output logic              golden_ok,
  output logic              proto_err,
  output logic [CNT_W-1:0]  n_faults,
  output logic [CNT_W-1:0]  n_detected
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GOLD  = 2'd1,
    CHECK = 2'd2,
    EMIT  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [VIDX_W-1:0]   vidx_q, vidx_d;
  logic [FID_W-1:0]    fid_q, fid_d;
  logic                det_q, det_d;
  logic [VIDX_W-1:0]   first_q, first_d;
  logic [VIDX_W:0]     mcount_q, mcount_d;
  logic                gok_q, gok_d;
  logic                perr_q, perr_d;
  logic [CNT_W-1:0]    nf_q, nf_d;
  logic [CNT_W-1:0]    nd_q, nd_d;

  // Golden response store; contents are meaningful only while gok_q is set.
  logic [DATA_W-1:0]   golden_q [MAXVEC];
  logic                gold_we;

  logic                xfer;
  logic                last_word;
  logic                mismatch;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign resp_ready = (state_q == GOLD) || (state_q == CHECK);
  assign xfer       = resp_valid && resp_ready;
  assign last_word  = (vidx_q == VIDX_W'(NVEC - 1));
  assign mismatch   = (resp_data != golden_q[vidx_q]);

  assign rec_valid    = (state_q == EMIT);
  assign rec_fid      = fid_q;
  assign rec_detected = det_q;
  assign rec_first    = first_q;
  assign rec_mcount   = mcount_q;
  assign golden_ok    = gok_q;
  assign proto_err    = perr_q;
  assign n_faults     = nf_q;
  assign n_detected   = nd_q;

  // Control and record registers; a reset discards any pending record.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      vidx_q   <= '0;
      fid_q    <= '0;
      det_q    <= 1'b0;
      first_q  <= '0;
      mcount_q <= '0;
      gok_q    <= 1'b0;
      perr_q   <= 1'b0;
      nf_q     <= '0;
      nd_q     <= '0;
    end else begin
      state_q  <= state_d;
      vidx_q   <= vidx_d;
      fid_q    <= fid_d;
      det_q    <= det_d;
      first_q  <= first_d;
      mcount_q <= mcount_d;
      gok_q    <= gok_d;
      perr_q   <= perr_d;
      nf_q     <= nf_d;
      nd_q     <= nd_d;
    end
  end

  // Golden store write port; storage data is not reset.
  always_ff @(posedge clk) begin
    if (gold_we) begin
      golden_q[vidx_q] <= resp_data;
    end
  end

  // Pass sequencing, mismatch accumulation, record handshake and counters.
  always_comb begin
    state_d  = state_q;
    vidx_d   = vidx_q;
    fid_d    = fid_q;
    det_d    = det_q;
    first_d  = first_q;
    mcount_d = mcount_q;
    gok_d    = gok_q;
    perr_d   = perr_q;
    nf_d     = nf_q;
    nd_d     = nd_q;
    gold_we  = 1'b0;

    // Words offered while no pass is open are dropped and flagged.
    if ((state_q == IDLE) && resp_valid) begin
      perr_d = 1'b1;
    end

    if (pass_start && (state_q != EMIT)) begin
      // A start always wins over a word in the same cycle. Starting while a
      // pass is open aborts it; the store is invalid during a golden pass, so
      // a fault restart out of GOLD falls into the no-golden branch.
      if (state_q != IDLE) begin
        perr_d = 1'b1;
      end
      vidx_d = '0;
      if (pass_golden) begin
        state_d = GOLD;
        gok_d   = 1'b0;
      end else if (gok_q) begin
        state_d  = CHECK;
        fid_d    = pass_fid;
        det_d    = 1'b0;
        first_d  = '0;
        mcount_d = '0;
      end else begin
        state_d = IDLE;
        perr_d  = 1'b1;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
        end
        GOLD: begin
          if (xfer) begin
            gold_we = 1'b1;
            if (last_word) begin
              gok_d   = 1'b1;
              vidx_d  = '0;
              state_d = IDLE;
            end else begin
              vidx_d = vidx_q + VIDX_W'(1);
            end
          end
        end
        CHECK: begin
          if (xfer) begin
            if (mismatch) begin
              det_d    = 1'b1;
              mcount_d = mcount_q + (VIDX_W + 1)'(1);
              if (mcount_q == '0) begin
                first_d = vidx_q;
              end
            end
            if (last_word) begin
              vidx_d  = '0;
              state_d = EMIT;
            end else begin
              vidx_d = vidx_q + VIDX_W'(1);
            end
          end
        end
        EMIT: begin
          // A start here is refused; the record stays pending.
          if (pass_start) begin
            perr_d = 1'b1;
          end
          if (rec_ready) begin
            state_d = IDLE;
            nf_d    = sat_inc(nf_q);
            if (det_q) begin
              nd_d = sat_inc(nd_q);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fault_response_checker.sv
// Bench for fault_response_checker: table of golden/fault passes, hand-written
// corner sequences, and randomized passes against a behavioural model.
module tb_fault_response_checker;

  typedef logic [128:0] w_t;

  typedef struct packed {
    logic        gold;
    logic [15:0] fid;
    w_t          w0;
    w_t          w1;
    w_t          w2;
    logic        det;
    logic [3:0]  first;
    logic [4:0]  mc;
    logic [15:0] nf;
    logic [15:0] nd;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        pass_start;
  logic        pass_golden;
  logic [15:0] pass_fid;
  logic        resp_valid;
  w_t          resp_data;
  logic        rec_ready;

  logic        resp_ready, rec_valid, rec_detected, golden_ok, proto_err;
  logic [15:0] rec_fid, n_faults, n_detected;
  logic [3:0]  rec_first;
  logic [4:0]  rec_mcount;

  logic        resp_ready_s, rec_valid_s, rec_detected_s, golden_ok_s, proto_err_s;
  logic [15:0] rec_fid_s;
  logic [3:0]  rec_first_s;
  logic [4:0]  rec_mcount_s;
  logic [1:0]  n_faults_s, n_detected_s;

  fault_response_checker #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .pass_start(pass_start), .pass_golden(pass_golden),
    .pass_fid(pass_fid), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_fid(rec_fid), .rec_detected(rec_detected), .rec_first(rec_first),
    .rec_mcount(rec_mcount), .golden_ok(golden_ok), .proto_err(proto_err),
    .n_faults(n_faults), .n_detected(n_detected)
  );

  fault_response_checker #(.CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .pass_start(pass_start), .pass_golden(pass_golden),
    .pass_fid(pass_fid), .resp_valid(resp_valid), .resp_ready(resp_ready_s),
    .resp_data(resp_data), .rec_valid(rec_valid_s), .rec_ready(rec_ready),
    .rec_fid(rec_fid_s), .rec_detected(rec_detected_s), .rec_first(rec_first_s),
    .rec_mcount(rec_mcount_s), .golden_ok(golden_ok_s), .proto_err(proto_err_s),
    .n_faults(n_faults_s), .n_detected(n_detected_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int npass = 0;
  int ntot  = 0;

  // Reference model state
  w_t cur [3];
  w_t mdl_gold [3];
  int mdl_nf;
  int mdl_nd;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h required %0h", nm, act, exp);
  endtask

  function automatic int sat(input int n, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  function automatic w_t rand129();
    w_t r;
    r[31:0]   = $urandom;
    r[63:32]  = $urandom;
    r[95:64]  = $urandom;
    r[127:96] = $urandom;
    r[128]    = 1'($urandom);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; pass_start = 1'b0; pass_golden = 1'b0; pass_fid = '0;
    resp_valid = 1'b0; resp_data = '0; rec_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    mdl_nf = 0;
    mdl_nd = 0;
  endtask

  task automatic start_pass(input logic g, input logic [15:0] fid);
    pass_start = 1'b1; pass_golden = g; pass_fid = fid;
    tick();
    pass_start = 1'b0;
  endtask

  task automatic send_words(input int gap_max);
    int n;
    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(gap_max, 0)) tick();
      resp_valid = 1'b1;
      resp_data  = cur[i];
      n = 0;
      while (!resp_ready && n < 20) begin tick(); n++; end
      if (!resp_ready) chk("resp_ready_wait", resp_ready, 1);
      tick();
      resp_valid = 1'b0;
    end
  endtask

  task automatic do_golden(input int gap);
    start_pass(1'b1, 16'd0);
    send_words(gap);
    for (int i = 0; i < 3; i++) mdl_gold[i] = cur[i];
  endtask

  // Expected record: which vectors differ from the stored golden pass.
  task automatic model_fault(output logic det, output logic [3:0] first, output logic [4:0] mc);
    int cnt;
    int f;
    cnt = 0; f = 0;
    for (int i = 0; i < 3; i++) begin
      if (cur[i] !== mdl_gold[i]) begin
        if (cnt == 0) f = i;
        cnt++;
      end
    end
    det = (cnt > 0); first = 4'(f); mc = 5'(cnt);
  endtask

  task automatic get_rec(input logic [15:0] fid, input logic det, input logic [3:0] first,
                         input logic [4:0] mc, input int stall);
    int n;
    chk("rec_latency", rec_valid, 1);
    n = 0;
    while (!rec_valid && n < 10) begin tick(); n++; end
    chk("rec_fid", rec_fid, fid);
    chk("rec_detected", rec_detected, det);
    chk("rec_first", rec_first, first);
    chk("rec_mcount", rec_mcount, mc);
    chk("rec_detected_s", rec_detected_s, det);
    repeat (stall) tick();
    rec_ready = 1'b1;
    tick();
    rec_ready = 1'b0;
    mdl_nf++;
    if (det) mdl_nd++;
    chk("rec_valid_after_hs", rec_valid, 0);
    chk("n_faults", n_faults, sat(mdl_nf, 16));
    chk("n_detected", n_detected, sat(mdl_nd, 16));
    chk("n_faults_sat", n_faults_s, sat(mdl_nf, 2));
    chk("n_detected_sat", n_detected_s, sat(mdl_nd, 2));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  initial begin
    logic       e_det;
    logic [3:0] e_first;
    logic [4:0] e_mc;
    int         idx;

    tbl[0] = '{gold:1'b1, fid:16'd0,  w0:'0, w1:'0, w2:'0,
               det:1'b0, first:4'd0, mc:5'd0, nf:16'd0, nd:16'd0};
    tbl[1] = '{gold:1'b0, fid:16'd5,  w0:'0, w1:'0, w2:'0,
               det:1'b0, first:4'd0, mc:5'd0, nf:16'd1, nd:16'd0};
    tbl[2] = '{gold:1'b0, fid:16'd7,  w0:'0, w1:129'd1, w2:'0,
               det:1'b1, first:4'd1, mc:5'd1, nf:16'd2, nd:16'd1};
    tbl[3] = '{gold:1'b1, fid:16'd0,  w0:{1'b1, 128'h0}, w1:'0, w2:'0,
               det:1'b0, first:4'd0, mc:5'd0, nf:16'd2, nd:16'd1};
    tbl[4] = '{gold:1'b0, fid:16'd3,  w0:'0, w1:'0, w2:'0,
               det:1'b1, first:4'd0, mc:5'd1, nf:16'd3, nd:16'd2};
    tbl[5] = '{gold:1'b0, fid:16'd11, w0:'0, w1:{2'b01, 127'h0}, w2:{129{1'b1}},
               det:1'b1, first:4'd0, mc:5'd3, nf:16'd4, nd:16'd3};

    // Reset state
    do_reset();
    chk("rst_rec_valid", rec_valid, 0);
    chk("rst_resp_ready", resp_ready, 0);
    chk("rst_golden_ok", golden_ok, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_n_faults", n_faults, 0);
    chk("rst_n_detected", n_detected, 0);
    chk("rst_rec_fid", rec_fid, 0);
    chk("rst_rec_fields", {rec_detected, rec_first, rec_mcount}, 0);

    // Fault pass with no golden store
    start_pass(1'b0, 16'd1);
    chk("nogold_proto_err", proto_err, 1);
    chk("nogold_idle", resp_ready, 0);
    tick();
    chk("nogold_still_idle", resp_ready, 0);
    do_reset();
    chk("perr_cleared_by_reset", proto_err, 0);

    // Word offered in IDLE
    resp_valid = 1'b1; resp_data = '0;
    tick();
    resp_valid = 1'b0;
    chk("idle_word_proto_err", proto_err, 1);
    chk("idle_word_not_ready", resp_ready, 0);
    do_reset();

    // Table-driven passes
    for (int r = 0; r < 6; r++) begin
      cur[0] = tbl[r].w0; cur[1] = tbl[r].w1; cur[2] = tbl[r].w2;
      if (tbl[r].gold) begin
        do_golden(0);
        chk("tbl_golden_ok", golden_ok, 1);
        chk("tbl_golden_no_rec", rec_valid, 0);
      end else begin
        start_pass(1'b0, tbl[r].fid);
        send_words(0);
        get_rec(tbl[r].fid, tbl[r].det, tbl[r].first, tbl[r].mc, r % 3);
      end
      chk("tbl_n_faults", n_faults, tbl[r].nf);
      chk("tbl_n_detected", n_detected, tbl[r].nd);
    end
    chk("tbl_no_proto_err", proto_err, 0);

    // Record back-pressure; start during EMIT is refused
    for (int i = 0; i < 3; i++) cur[i] = mdl_gold[i];
    cur[2][5] = ~cur[2][5];
    start_pass(1'b0, 16'd12);
    send_words(0);
    resp_valid = 1'b1; resp_data = cur[0];
    for (int k = 0; k < 10; k++) begin
      chk("bp_rec_valid", rec_valid, 1);
      chk("bp_fields", {rec_fid, rec_detected, rec_first, rec_mcount}, {16'd12, 1'b1, 4'd2, 5'd1});
      chk("bp_resp_ready", resp_ready, 0);
      chk("bp_proto_err", proto_err, (k >= 5) ? 1 : 0);
      if (k == 4) begin pass_start = 1'b1; pass_golden = 1'b1; end
      tick();
      pass_start = 1'b0;
    end
    resp_valid = 1'b0;
    get_rec(16'd12, 1'b1, 4'd2, 5'd1, 0);
    chk("bp_idle_after", resp_ready, 0);

    // Abort a fault pass; restart wins over a simultaneous last word
    do_reset();
    for (int i = 0; i < 3; i++) cur[i] = rand129();
    do_golden(1);
    start_pass(1'b0, 16'd8);
    for (int i = 0; i < 2; i++) begin
      resp_valid = 1'b1; resp_data = cur[i];
      tick();
    end
    resp_data = cur[2]; pass_start = 1'b1; pass_golden = 1'b0; pass_fid = 16'd9;
    tick();
    pass_start = 1'b0; resp_valid = 1'b0;
    chk("abort_proto_err", proto_err, 1);
    chk("abort_no_rec", rec_valid, 0);
    chk("abort_restart_check", resp_ready, 1);
    cur[1][7] = ~cur[1][7];
    send_words(0);
    get_rec(16'd9, 1'b1, 4'd1, 5'd1, 1);
    chk("abort_one_record", n_faults, 1);

    // Abort a golden pass: store is invalidated
    start_pass(1'b1, 16'd0);
    resp_valid = 1'b1; resp_data = rand129();
    tick();
    resp_valid = 1'b0;
    start_pass(1'b0, 16'd3);
    chk("gabort_golden_ok", golden_ok, 0);
    chk("gabort_idle", resp_ready, 0);

    // Randomized passes against the model
    for (int p = 0; p < 40; p++) begin
      if (p == 0 || $urandom_range(5, 0) == 0) begin
        for (int i = 0; i < 3; i++) cur[i] = rand129();
        do_golden(2);
        chk("rnd_golden_ok", golden_ok, 1);
      end
      for (int i = 0; i < 3; i++) begin
        cur[i] = mdl_gold[i];
        if ($urandom_range(2, 0) == 0) begin
          idx = $urandom_range(128, 0);
          cur[i][idx] = ~cur[i][idx];
        end
      end
      model_fault(e_det, e_first, e_mc);
      start_pass(1'b0, 16'($urandom));
      send_words(2);
      get_rec(pass_fid, e_det, e_first, e_mc, $urandom_range(3, 0));
    end

    // Counter saturation with a 2-bit counter instance
    do_reset();
    for (int i = 0; i < 3; i++) cur[i] = rand129();
    do_golden(0);
    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < 3; i++) cur[i] = mdl_gold[i];
      cur[0][p] = ~cur[0][p];
      start_pass(1'b0, 16'(20 + p));
      send_words(0);
      get_rec(16'(20 + p), 1'b1, 4'd0, 5'd1, 0);
    end
    chk("sat_n_faults", n_faults_s, 3);
    chk("sat_n_detected", n_detected_s, 3);
    chk("wide_n_faults", n_faults, 5);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
